// File: rtl/int_to_float_seq.sv
// int_to_float_seq
// Sequential converter from a 32-bit signed two's-complement integer to an
// IEEE-754 single-precision word. Normalisation runs one bit position per
// clock. The result is truncated toward zero and is never rounded.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous, active-high reset
//   in_valid   operand on in_int is valid
//   in_ready   block can accept an operand (high only in IDLE)
//   in_int     signed 32-bit operand
//   out_valid  result is valid; held until accepted
//   out_ready  consumer accepts result
//   result     {sign, exp[7:0], mantissa[22:0]}
//   busy       conversion in progress or result waiting (NORM or DONE)
//   dbg_state  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid, and keeps its data stable, until that
// edge. Valid never depends on ready. The block drives in_ready and
// out_valid from state only, so no combinational path runs from in_* to out_*.
module int_to_float_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_int,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [31:0] mag_q, mag_d;
   logic [7:0]  exp_q, exp_d;
   logic [31:0] result_q, result_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         mag_q    <= 32'd0;
         exp_q    <= 8'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         exp_q    <= exp_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      exp_d    = exp_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = in_int[31];
               // Negating 0x80000000 wraps back to 0x80000000. Read as an
               // unsigned number, that is the correct magnitude, 2^31.
               mag_d  = in_int[31] ? (~in_int + 32'd1) : in_int;
               // The value is mag * 2^0. Start by treating the leading bit as
               // bit 31, which is bias 127 + 31. Each shift then takes one off.
               exp_d  = 8'd158;
               if (in_int == 32'd0) begin
                  result_d = 32'h0000_0000;
                  state_d  = DONE;
               end else begin
                  state_d  = NORM;
               end
            end
         end
         NORM: begin
            if (mag_q[31]) begin
               // The hidden bit is mag[31]. mag[7:0] falls off the end, which
               // truncates toward zero.
               result_d = {sign_q, exp_q, mag_q[30:8]};
               state_d  = DONE;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 8'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Bench for int_to_float_seq. The reference model works from the numeric
// value of the operand. It finds the highest set bit of |x|. The exponent is
// 127 plus that position. The fraction is the remainder below that bit,
// scaled down to 23 bits by truncation.
module tb_int_to_float_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_int;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_errors;
   logic [31:0] exp_q[$];

   int_to_float_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_int    (in_int),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int top_bit(input logic [31:0] v);
      longint m;
      int p;
      m = longint'($signed(v));
      if (m < 0) m = -m;
      p = -1;
      for (int i = 0; i < 32; i++) begin
         if (m >= (longint'(1) << i)) p = i;
      end
      return p;
   endfunction

   function automatic logic [31:0] ref_conv(input logic [31:0] v);
      longint m;
      longint rem;
      int p;
      logic [22:0] man;
      if (v == 32'd0) return 32'd0;
      m = longint'($signed(v));
      if (m < 0) m = -m;
      p = top_bit(v);
      rem = m - (longint'(1) << p);
      if (p >= 23) man = 23'(rem >> (p - 23));
      else         man = 23'(rem << (23 - p));
      return {v[31], 8'(127 + p), man};
   endfunction

   // Number of rising edges after the acceptance edge until DONE is entered.
   // Each shift takes one edge, and the pack takes one more.
   function automatic int ref_lat(input logic [31:0] v);
      if (v == 32'd0) return 0;
      return (31 - top_bit(v)) + 1;
   endfunction

   // ---------------- driver ----------------
   // Drives one operand and waits for its result. The bench drives and samples
   // on falling edges. If hold > 0, out_ready stays low for that many cycles.
   // During that time result must stay stable and in_ready must stay low. A
   // stray in_valid is also pulsed, and the block must ignore it.
   task automatic convert(input logic [31:0] v, input int hold);
      int w;
      int lat;
      logic [31:0] held;
      exp_q.push_back(ref_conv(v));
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_int   = v;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_int   = $urandom;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(ref_lat(v)));
      held = result;
      for (int i = 0; i < hold; i++) begin
         if (i == 3) begin
            in_valid = 1'b1;
            in_int   = ~v;
         end
         if (i == 4) in_valid = 1'b0;
         @(negedge clk);
         check("bp_result_stable", result, held);
         check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      check("result", result, exp_q.pop_front());
      check("busy_in_done", {31'd0, busy}, 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      if (hold > 0) check("result_kept_after_hs", result, held);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] v;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_int    = 32'd0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-NORM drops the partial conversion.
      in_valid = 1'b1;
      in_int   = 32'h0000_0001;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      convert(32'h0000_0003, 0);

      // Directed cases: basics, extremes, truncation.
      convert(32'h0000_0001, 0);
      convert(32'hFFFF_FFFF, 0);
      convert(32'h0000_0000, 0);
      convert(32'h8000_0000, 0);
      convert(32'h7FFF_FFFF, 0);
      convert(32'h0100_0001, 0);
      convert(32'hFEFF_FFFF, 0);   // -16777217
      check("const_one", ref_conv(32'h0000_0001), 32'h3F80_0000);

      // Backpressure, with a stray in_valid pulse while DONE is held.
      convert(32'h0000_0005, 10);

      // Random stream covering a range of leading-zero counts and both signs.
      for (int i = 0; i < 100; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
         if ($urandom_range(0, 15) == 0) v = 32'd0;
         convert(v, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
